// File: rtl/piso_pkg.sv
// Shared state encodings for the PISO serializer and the SIPO deserializer that follows it.
package piso_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_SHIFT  = ST_SHIFT,
      S_PARITY = ST_PARITY
   } piso_state_t;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out converter with valid/ready load and gapless back-to-back frames.
// Optional even-parity bit after the data bits when PISO_PARITY_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | no frame; so holds last bit, pi_ready=1
// S_SHIFT  | so carries data bit number cnt (0..WIDTH-1)
// S_PARITY | so carries the parity bit (cnt=WIDTH), parity build only
module piso_serializer
   import piso_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pi,
   input  logic             pi_valid,
   output logic             pi_ready,
   input  logic             lsb_first,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH-1);
`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIDTH);
`else
   localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WIDTH-1);
`endif

   piso_state_t      state_q, state_d;
   logic [WIDTH-1:0] sreg_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lsb_q;
   logic             so_q;
   logic             load, step, to_par;
`ifdef PISO_PARITY_EN
   logic             par_q;
`endif

   assign so_valid = (state_q != S_IDLE);
   assign busy     = so_valid;
   assign so_last  = so_valid && (cnt_q == LAST_IDX);
   assign pi_ready = (state_q == S_IDLE) || so_last;
   assign load     = pi_valid && pi_ready;
   assign so       = so_q;

   always_comb begin
      state_d = state_q;
      step    = 1'b0;
      to_par  = 1'b0;
      case (state_q)
         S_IDLE:   if (load) state_d = S_SHIFT;
         S_SHIFT: begin
            if (cnt_q != DATA_LAST) begin
               step = 1'b1;
            end else begin
`ifdef PISO_PARITY_EN
               state_d = S_PARITY;
               to_par  = 1'b1;
`else
               state_d = load ? S_SHIFT : S_IDLE;
`endif
            end
         end
         S_PARITY: state_d = load ? S_SHIFT : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         lsb_q   <= 1'b0;
         so_q    <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (load) begin
            // first bit goes straight to so so it appears the cycle after the accepting edge
            lsb_q <= lsb_first;
            cnt_q <= '0;
            if (lsb_first) begin
               so_q   <= pi[0];
               sreg_q <= pi >> 1;
            end else begin
               so_q   <= pi[WIDTH-1];
               sreg_q <= pi << 1;
            end
`ifdef PISO_PARITY_EN
            par_q <= ^pi;
`endif
         end else if (step) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            so_q   <= lsb_q ? sreg_q[0] : sreg_q[WIDTH-1];
            sreg_q <= lsb_q ? (sreg_q >> 1) : (sreg_q << 1);
         end else if (to_par) begin
`ifdef PISO_PARITY_EN
            cnt_q <= cnt_q + CNT_W'(1);
            so_q  <= par_q;
`endif
         end else if (state_d == S_IDLE) begin
            cnt_q <= '0;
         end
      end
   end

endmodule
